lfsr_word_harvester: RTL and testbench



---
 rtl/lfsr_word_harvester.sv | 160 ++++++++++++++++
 tb/tb_lfsr_word_harvester.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_word_harvester.sv
// Harvests the MSB of a Galois LFSR into packed words and buffers them in a small FIFO.
// Optional all-zero lock-up detection is enabled by defining LFSR_STUCK_DETECT_EN.
module lfsr_word_harvester #(
    parameter int unsigned NBITS     = 16,
    parameter int unsigned WORD_BITS = 8,
    parameter int unsigned DECIMATE  = 1,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic [NBITS-1:0]             lfsr_in,
    output logic                         lfsr_en,
    output logic [WORD_BITS-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         stuck
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned BW = $clog2(WORD_BITS + 1);
    localparam int unsigned DW = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;

    localparam logic [DW-1:0] DLast = DW'(DECIMATE - 1);
    localparam logic [BW-1:0] BLast = BW'(WORD_BITS - 1);
    localparam logic [LW-1:0] LFull = LW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StShift, StPush} state_e;

    state_e                 state_q, state_d;
    logic [BW-1:0]          bcnt_q, bcnt_d;
    logic [DW-1:0]          dcnt_q, dcnt_d;
    logic [WORD_BITS-1:0]   sr_q, sr_d;
    logic                   stuck_q, stuck_d;
    logic [WORD_BITS-1:0]   mem_q [DEPTH];
    logic [WORD_BITS-1:0]   mem_d [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;

    logic push;
    logic pop;
    logic zero_hit;
    logic not_empty;

`ifdef LFSR_STUCK_DETECT_EN
    assign zero_hit = (lfsr_in == '0);
    assign stuck    = stuck_q;
`else
    logic unused_lfsr_low;
    assign unused_lfsr_low = ^lfsr_in[NBITS-2:0];
    assign zero_hit        = 1'b0;
    assign stuck           = 1'b0;
`endif

    assign not_empty = (level_q != '0);
    assign pop       = not_empty & out_ready;

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        dcnt_d  = dcnt_q;
        sr_d    = sr_q;
        stuck_d = stuck_q;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run && !stuck_q) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (!run) begin
                    state_d = StIdle;
                    bcnt_d  = '0;
                    dcnt_d  = '0;
                    sr_d    = '0;
                end else if (dcnt_q == DLast) begin
                    dcnt_d = '0;
                    if (zero_hit) begin
                        // A locked-up LFSR would only ever yield zeros; abandon the word.
                        stuck_d = 1'b1;
                        state_d = StIdle;
                        bcnt_d  = '0;
                        sr_d    = '0;
                    end else begin
                        sr_d = {sr_q[WORD_BITS-2:0], lfsr_in[NBITS-1]};
                        if (bcnt_q == BLast) begin
                            bcnt_d  = '0;
                            state_d = StPush;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            StPush: begin
                // A full FIFO still has room if the head is popped this same cycle.
                if ((level_q != LFull) || pop) begin
                    push    = 1'b1;
                    state_d = run ? StShift : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = sr_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            bcnt_q   <= '0;
            dcnt_q   <= '0;
            sr_q     <= '0;
            stuck_q  <= 1'b0;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            dcnt_q   <= dcnt_d;
            sr_q     <= sr_d;
            stuck_q  <= stuck_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign lfsr_en   = (state_q == StShift) && !reset;
    assign out_valid = not_empty;
    assign out_data  = not_empty ? mem_q[rd_ptr_q] : '0;
    assign level     = level_q;

endmodule

// File: tb/tb_lfsr_word_harvester.sv
// Self-checking bench for lfsr_word_harvester; a bench-side Galois LFSR feeds lfsr_in and
// expected words are derived from that LFSR's MSB stream.
module tb_lfsr_word_harvester;

    localparam logic [15:0] TAPS = 16'h001D;
    localparam logic [15:0] SEED = 16'h0001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] lfsr_in = 16'h0000;
    logic        lfsr_en;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [2:0]  level;
    logic        stuck;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    bit lfsr_mode = 1'b0;
    logic [15:0] st = SEED;

    lfsr_word_harvester dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .lfsr_in   (lfsr_in),
        .lfsr_en   (lfsr_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .stuck     (stuck)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] sh;
        sh = s << 1;
        return s[15] ? (sh ^ TAPS) : sh;
    endfunction

    // Word k of the reference stream: MSBs of LFSR states 8k..8k+7, first state MSB-first.
    function automatic logic [7:0] model_word(input int k);
        logic [15:0] s;
        logic [7:0]  w;
        s = SEED;
        w = 8'h00;
        for (int i = 0; i < 8 * k; i++) s = lfsr_next(s);
        for (int b = 0; b < 8; b++) begin
            w = {w[6:0], s[15]};
            s = lfsr_next(s);
        end
        return w;
    endfunction

    task automatic tick();
        logic en;
        en = lfsr_en;
        if (en) en_cnt++;
        @(posedge clk);
        #1;
        if (lfsr_mode && en) st = lfsr_next(st);
        if (lfsr_mode) lfsr_in = st;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        st = SEED;
        if (lfsr_mode) lfsr_in = st;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run = 1'b1;
        tick();
        tick();
        checks++;
        if (lfsr_en !== 1'b0) begin
            errors++; $display("FAIL reset_en: got %b want 0", lfsr_en);
        end
        checks++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            errors++; $display("FAIL reset_fifo: valid=%b level=%0d want 0/0", out_valid, level);
        end
        checks++;
        if (out_data !== 8'h00 || stuck !== 1'b0) begin
            errors++; $display("FAIL reset_data: data=%h stuck=%b want 00/0", out_data, stuck);
        end
        reset = 1'b0;
        run = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        int rise_cyc [3];
        int rise_en  [3];
        logic [7:0] first_data;
        int n;
        logic prev_v;
        lfsr_mode = 1'b0;
        lfsr_in = 16'h8000;
        do_reset();
        out_ready = 1'b1;
        run = 1'b1;
        en_cnt = 0;
        n = 0;
        prev_v = 1'b0;
        first_data = 8'h00;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (out_valid && !prev_v && n < 3) begin
                rise_cyc[n] = c;
                rise_en[n] = en_cnt;
                if (n == 0) first_data = out_data;
                n++;
            end
            prev_v = out_valid;
        end
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL latency_words: got %0d want 3", n);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rise_cyc[i] != 10 + 9 * i || rise_en[i] != 8 * (i + 1)) begin
                    errors++;
                    $display("FAIL latency_word%0d: cycle=%0d en=%0d want %0d/%0d", i,
                             rise_cyc[i], rise_en[i], 10 + 9 * i, 8 * (i + 1));
                end
            end
        end
        checks++;
        if (first_data !== 8'hFF) begin
            errors++; $display("FAIL latency_data: got %h want ff", first_data);
        end
        run = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        int got;
        logic prev_stall;
        logic [7:0] prev_data;
        logic [7:0] exp;
        lfsr_mode = 1'b1;
        do_reset();
        run = 1'b1;
        got = 0;
        prev_stall = 1'b0;
        prev_data = 8'h00;
        for (int c = 0; c < 4000 && got < 64; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL stream_stable: valid=%b data=%h want 1/%h", out_valid,
                             out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                exp = model_word(got);
                checks++;
                if (out_data !== exp) begin
                    errors++; $display("FAIL stream_word%0d: got %h want %h", got, out_data, exp);
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            tick();
        end
        checks++;
        if (got != 64) begin
            errors++; $display("FAIL stream_timeout: got %0d words want 64", got);
        end
        run = 1'b0;
        out_ready = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        lfsr_mode = 1'b1;
        do_reset();
        out_ready = 1'b0;
        run = 1'b1;
        repeat (60) tick();
        checks++;
        if (level !== 3'd4 || lfsr_en !== 1'b0) begin
            errors++; $display("FAIL bp_full: level=%0d en=%b want 4/0", level, lfsr_en);
        end
        en_cnt = 0;
        repeat (20) tick();
        checks++;
        if (en_cnt != 0 || level !== 3'd4) begin
            errors++; $display("FAIL bp_frozen: en_cycles=%0d level=%0d want 0/4", en_cnt, level);
        end
        checks++;
        if (out_data !== model_word(0)) begin
            errors++; $display("FAIL bp_head: got %h want %h", out_data, model_word(0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (level !== 3'd4 || lfsr_en !== 1'b1) begin
            errors++; $display("FAIL bp_pulse: level=%0d en=%b want 4/1", level, lfsr_en);
        end
        run = 1'b0;
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== model_word(k)) begin
                errors++;
                $display("FAIL bp_drain%0d: valid=%b data=%h want 1/%h", k, out_valid, out_data,
                         model_word(k));
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            errors++; $display("FAIL bp_empty: valid=%b level=%0d want 0/0", out_valid, level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_run_drop();
        logic [7:0] exp;
        logic seen_valid;
        lfsr_mode = 1'b0;
        do_reset();
        out_ready = 1'b1;
        lfsr_in = 16'hFFFF;
        run = 1'b1;
        repeat (6) tick();
        run = 1'b0;
        checks++;
        if (lfsr_en !== 1'b1) begin
            errors++; $display("FAIL drop_en_before: got %b want 1", lfsr_en);
        end
        tick();
        checks++;
        if (lfsr_en !== 1'b0) begin
            errors++; $display("FAIL drop_en_after: got %b want 0", lfsr_en);
        end
        seen_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) seen_valid = 1'b1;
            tick();
        end
        checks++;
        if (seen_valid) begin
            errors++; $display("FAIL drop_no_push: got valid=1 want 0");
        end
        exp = 8'h00;
        run = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            if (c >= 1 && c <= 8) begin
                lfsr_in = 16'($urandom());
                exp = {exp[6:0], lfsr_in[15]};
            end else begin
                lfsr_in = 16'hFFFF;
            end
            if (c == 9) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL drop_early: got valid=%b want 0", out_valid);
                end
            end
            if (c == 10) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp) begin
                    errors++;
                    $display("FAIL drop_word: valid=%b data=%h want 1/%h", out_valid, out_data,
                             exp);
                end
            end
            if (c < 10) tick();
        end
        run = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int c;
        lfsr_mode = 1'b1;
        do_reset();
        out_ready = 1'b0;
        run = 1'b1;
        c = 0;
        while (level !== 3'd3 && c < 100) begin
            tick();
            c++;
        end
        tick();
        tick();
        checks++;
        if (level !== 3'd3 || lfsr_en !== 1'b1) begin
            errors++; $display("FAIL rmid_pre: level=%0d en=%b want 3/1", level, lfsr_en);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (level !== 3'd0 || out_valid !== 1'b0 || lfsr_en !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL rmid_clear: level=%0d valid=%b en=%b data=%h want 0/0/0/00", level,
                     out_valid, lfsr_en, out_data);
        end
        reset = 1'b0;
        checks++;
        if (lfsr_en !== 1'b0) begin
            errors++; $display("FAIL rmid_idle: en=%b want 0", lfsr_en);
        end
        tick();
        checks++;
        if (lfsr_en !== 1'b1) begin
            errors++; $display("FAIL rmid_restart: en=%b want 1", lfsr_en);
        end
        run = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_zero();
        lfsr_mode = 1'b0;
        do_reset();
        lfsr_in = 16'h0000;
        out_ready = 1'b0;
        run = 1'b1;
        en_cnt = 0;
        repeat (12) tick();
`ifdef LFSR_STUCK_DETECT_EN
        checks++;
        if (stuck !== 1'b1 || lfsr_en !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL zero_stuck: stuck=%b en=%b level=%0d want 1/0/0", stuck, lfsr_en,
                     level);
        end
        checks++;
        if (en_cnt != 1) begin
            errors++; $display("FAIL zero_en_cycles: got %0d want 1", en_cnt);
        end
`else
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h00 || stuck !== 1'b0) begin
            errors++;
            $display("FAIL zero_word: valid=%b data=%h stuck=%b want 1/00/0", out_valid,
                     out_data, stuck);
        end
`endif
        run = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stream();
        test_backpressure();
        test_run_drop();
        test_reset_mid();
        test_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
